bcd_score_display: RTL

Parametrised N-digit multiplexed 7-segment score display: accepts a binary score on a load strobe, converts it to BCD with a sequential double-dabble engine, and time-multiplexes the digits onto a shared common-anode segment bus. It is the drop-in successor to the two-digit hex score display. It adds decimal output, saturation, leading-zero blanking, an anti-ghosting gap and blink, and it sits between the game scoring logic and the board's digit transistors.

---
 rtl/bcd_score_display.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_score_display.sv
// Multiplexed N-digit decimal score display: a sequential double-dabble converter feeds
// a display register that is scanned onto a shared active-low 7-segment bus.
module bcd_score_display #(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14,
  parameter int SLOT_W  = 16,
  parameter int BLINK_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blink_en,
  output logic               busy,
  output logic [DIGITS-1:0]  digit_en,
  output logic [6:0]         seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(VALUE_W - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [VALUE_W-1:0] saturate(input logic [VALUE_W-1:0] v);
    if (64'(v) > MAX_VAL) begin
      return VALUE_W'(MAX_VAL);
    end else begin
      return v;
    end
  endfunction

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [VALUE_W-1:0] pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic               busy_q, busy_d;
  logic [SLOT_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLINK_W:0]   blink_q, blink_d;
  logic [DIGITS-1:0]  digit_en_q, digit_en_d;
  logic [6:0]         seg_q, seg_d;
  logic [BCD_W-1:0]   adj_s;
  logic [DIGITS-1:0]  lz_s;
  logic               zero_run_s;
  logic [3:0]         cur_digit_s;
  logic               dark_s;

  assign adj_s = dd_adjust(bcd_q);

  // Converter FSM: a load in COMMIT (or a waiting pending value) chains straight into SHIFT.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SHIFT;
          bin_d   = saturate(value);
          bcd_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj_s[BCD_W-2:0], bin_q[VALUE_W-1]};
        bin_d = {bin_q[VALUE_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
        if (load) begin
          pend_d   = value;
          pend_v_d = 1'b1;
        end else begin
          pend_v_d = pend_v_q;
        end
      end
      ST_COMMIT: begin
        disp_d = bcd_q;
        bcd_d  = '0;
        cnt_d  = '0;
        if (load) begin
          state_d  = ST_SHIFT;
          bin_d    = saturate(value);
          pend_v_d = 1'b0;
        end else if (pend_v_q) begin
          state_d  = ST_SHIFT;
          bin_d    = saturate(pend_q);
          pend_v_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Converter and display register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      busy_q   <= busy_d;
    end
  end

  // Free-running slot prescaler, digit index and blink timer.
  always_comb begin
    presc_d = presc_q + SLOT_W'(1);
    blink_d = blink_q + (BLINK_W+1)'(1);
    if (presc_q == {SLOT_W{1'b1}}) begin
      idx_d = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Scan output: the first 4 cycles of a slot are dark so the previous digit fully turns off.
  always_comb begin
    zero_run_s  = 1'b1;
    lz_s        = '0;
    cur_digit_s = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (disp_q[4*i +: 4] == 4'd0);
      lz_s[i]    = zero_run_s;
    end
    for (int i = 0; i < DIGITS; i++) begin
      cur_digit_s = (idx_q == IDX_W'(i)) ? disp_q[4*i +: 4] : cur_digit_s;
    end
    dark_s = (presc_q < SLOT_W'(4))
           || ((idx_q != {IDX_W{1'b0}}) && lz_s[idx_q])
           || (blink_en && blink_q[BLINK_W]);
    if (dark_s) begin
      digit_en_d = {DIGITS{1'b1}};
      seg_d      = 7'h7F;
    end else begin
      digit_en_d = ~(DIG_ONE << idx_q);
      seg_d      = seg7(cur_digit_s);
    end
  end

  // Scan counters and registered display drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      blink_q    <= '0;
      digit_en_q <= {DIGITS{1'b1}};
      seg_q      <= 7'h7F;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      blink_q    <= blink_d;
      digit_en_q <= digit_en_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = busy_q;
  assign digit_en = digit_en_q;
  assign seg      = seg_q;

endmodule
